// File: rtl/opl3_slot_sequencer_if.sv
// ----------------------------------------------------------------------------
// opl3_slot_sequencer_if
//   Host register-file write handshake used by the OPL3 slot sequencer.
//   The host (master) raises host_wr_req with a stable {bank, address} and
//   data word and holds them until the sequencer (slave) returns a one-cycle
//   host_wr_ack.
//
//   host_wr_req    master -> slave  write request
//   host_wr_addr   master -> slave  {bank, address}, ADDR_WIDTH+1 bits
//   host_wr_data   master -> slave  write data, DATA_WIDTH bits
//   host_wr_ack    slave  -> master one-cycle grant
// ----------------------------------------------------------------------------
interface opl3_slot_sequencer_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic                  host_wr_req;
   logic [ADDR_WIDTH:0]   host_wr_addr;
   logic [DATA_WIDTH-1:0] host_wr_data;
   logic                  host_wr_ack;

   modport master (
      output host_wr_req,
      output host_wr_addr,
      output host_wr_data,
      input  host_wr_ack
   );

   modport slave (
      input  host_wr_req,
      input  host_wr_addr,
      input  host_wr_data,
      output host_wr_ack
   );
endinterface

// File: rtl/opl3_slot_sequencer.sv
// ----------------------------------------------------------------------------
// opl3_slot_sequencer
//   Master timing controller for the OPL3 datapath.
//   - Divides clk into a one-cycle sample strobe every CLK_DIV clocks.
//   - After each sample strobe, walks the shared operator pipeline through all
//     NUM_BANKS*OPS_PER_BANK slots, SLOT_SPACING clocks per slot, flagging the
//     first cycle of every slot (the slot-latch cycle) and the final cycle of
//     the last slot.
//   - Arbitrates host register-file writes so a write never lands on a
//     slot-latch cycle, when the operator pipeline samples register contents.
//
// Ports
//   clk               master clock
//   reset             asynchronous reset, active-high
//   host              host write handshake (slave side)
//   sample_clk_en     one-cycle pulse per CLK_DIV clocks
//   op_sample_clk_en  one-cycle pulse on the first cycle of each slot
//   bank_num          bank of the current slot
//   op_num            operator index within the bank
//   frame_done        one-cycle pulse on the final cycle of the last slot
//   regfile_wr_en     register-file write strobe (coincident with ack)
//   regfile_wr_addr   registered {bank, address} of the granted write
//   regfile_wr_data   registered data of the granted write
//
// All outputs are registered.
// ----------------------------------------------------------------------------
module opl3_slot_sequencer #(
   parameter int CLK_DIV      = 256,
   parameter int NUM_BANKS    = 2,
   parameter int OPS_PER_BANK = 18,
   parameter int SLOT_SPACING = 4,
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   opl3_slot_sequencer_if.slave  host,
   output logic                  sample_clk_en,
   output logic                  op_sample_clk_en,
   output logic                  bank_num,
   output logic [4:0]            op_num,
   output logic                  frame_done,
   output logic                  regfile_wr_en,
   output logic [ADDR_WIDTH:0]   regfile_wr_addr,
   output logic [DATA_WIDTH-1:0] regfile_wr_data
);

   localparam int NUM_SLOTS = NUM_BANKS * OPS_PER_BANK;
   localparam int LAST_SLOT = NUM_SLOTS - 1;
   localparam int CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int PHASE_W   = (SLOT_SPACING > 1) ? $clog2(SLOT_SPACING) : 1;

   // A frame must finish before the next sample strobe arrives.
   if (NUM_SLOTS * SLOT_SPACING >= CLK_DIV) begin : g_bad_cfg
      $error("opl3_slot_sequencer: NUM_BANKS*OPS_PER_BANK*SLOT_SPACING must be < CLK_DIV");
   end

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                state_r;
   logic [CNT_W-1:0]      cnt_r;
   logic [SLOT_W-1:0]     slot_r;
   logic [PHASE_W-1:0]    phase_r;
   logic                  sample_clk_en_r;
   logic                  op_sample_clk_en_r;
   logic                  bank_r;
   logic [4:0]            op_r;
   logic                  frame_done_r;
   logic                  host_wr_ack_r;
   logic                  regfile_wr_en_r;
   logic [ADDR_WIDTH:0]   regfile_wr_addr_r;
   logic [DATA_WIDTH-1:0] regfile_wr_data_r;

   logic                  slot_end_s;
   logic                  last_slot_s;
   logic                  latch_next_s;
   logic                  frame_next_s;
   logic                  grant_s;

   // Sample-rate divider: free-running count, strobe registered on the wrap value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r           <= CNT_W'(0);
         sample_clk_en_r <= 1'b0;
      end else begin
         sample_clk_en_r <= (cnt_r == CNT_W'(CLK_DIV - 1));
         if (cnt_r == CNT_W'(CLK_DIV - 1)) begin
            cnt_r <= CNT_W'(0);
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end
   end

   // Look-ahead: will the next cycle be a slot-latch cycle / the frame's final cycle?
   // The write arbiter needs the latch look-ahead to keep writes off latch cycles.
   always_comb begin
      slot_end_s   = (phase_r == PHASE_W'(SLOT_SPACING - 1));
      last_slot_s  = (slot_r == SLOT_W'(LAST_SLOT));
      latch_next_s = 1'b0;
      frame_next_s = 1'b0;
      if (sample_clk_en_r) begin
         // A sample strobe always (re)starts the frame at slot 0.
         latch_next_s = 1'b1;
         frame_next_s = (NUM_SLOTS == 1) && (SLOT_SPACING == 1);
      end else if (state_r == ST_RUN) begin
         if (slot_end_s) begin
            latch_next_s = !last_slot_s;
            frame_next_s = (SLOT_SPACING == 1) && (slot_r == SLOT_W'(LAST_SLOT - 1));
         end else begin
            latch_next_s = 1'b0;
            frame_next_s = last_slot_s && (phase_r == PHASE_W'(SLOT_SPACING - 2));
         end
      end else begin
         latch_next_s = 1'b0;
         frame_next_s = 1'b0;
      end
   end

   // Slot FSM: steps slot/phase, tracks bank/operator, drives latch and frame strobes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r            <= ST_IDLE;
         slot_r             <= SLOT_W'(0);
         phase_r            <= PHASE_W'(0);
         bank_r             <= 1'b0;
         op_r               <= 5'd0;
         op_sample_clk_en_r <= 1'b0;
         frame_done_r       <= 1'b0;
      end else begin
         op_sample_clk_en_r <= latch_next_s;
         frame_done_r       <= frame_next_s;
         if (sample_clk_en_r) begin
            state_r <= ST_RUN;
            slot_r  <= SLOT_W'(0);
            phase_r <= PHASE_W'(0);
            bank_r  <= 1'b0;
            op_r    <= 5'd0;
         end else if (state_r == ST_RUN) begin
            if (slot_end_s) begin
               phase_r <= PHASE_W'(0);
               if (last_slot_s) begin
                  // bank/op keep showing the last slot while idle.
                  state_r <= ST_IDLE;
                  slot_r  <= SLOT_W'(0);
               end else begin
                  slot_r <= slot_r + SLOT_W'(1);
                  if (op_r == 5'(OPS_PER_BANK - 1)) begin
                     op_r   <= 5'd0;
                     bank_r <= bank_r + 1'b1;
                  end else begin
                     op_r   <= op_r + 5'd1;
                  end
               end
            end else begin
               phase_r <= phase_r + PHASE_W'(1);
            end
         end else begin
            state_r <= ST_IDLE;
         end
      end
   end

   // Write grant: never two acks in a row, never into a slot-latch cycle.
   always_comb begin
      grant_s = host.host_wr_req && !host_wr_ack_r && !latch_next_s;
   end

   // Host write arbiter: registers the granted address/data alongside ack/strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         host_wr_ack_r     <= 1'b0;
         regfile_wr_en_r   <= 1'b0;
         regfile_wr_addr_r <= (ADDR_WIDTH + 1)'(0);
         regfile_wr_data_r <= DATA_WIDTH'(0);
      end else begin
         host_wr_ack_r   <= grant_s;
         regfile_wr_en_r <= grant_s;
         if (grant_s) begin
            regfile_wr_addr_r <= host.host_wr_addr;
            regfile_wr_data_r <= host.host_wr_data;
         end else begin
            regfile_wr_addr_r <= regfile_wr_addr_r;
            regfile_wr_data_r <= regfile_wr_data_r;
         end
      end
   end

   assign sample_clk_en    = sample_clk_en_r;
   assign op_sample_clk_en = op_sample_clk_en_r;
   assign bank_num         = bank_r;
   assign op_num           = op_r;
   assign frame_done       = frame_done_r;
   assign host.host_wr_ack = host_wr_ack_r;
   assign regfile_wr_en    = regfile_wr_en_r;
   assign regfile_wr_addr  = regfile_wr_addr_r;
   assign regfile_wr_data  = regfile_wr_data_r;

endmodule

// File: tb/tb_opl3_slot_sequencer.sv
// ----------------------------------------------------------------------------
// tb_opl3_slot_sequencer
//   Randomized host-write traffic against the slot sequencer. A reference
//   model derives every timing output from the cycle count since reset
//   release; writes are scoreboarded with their expected ack cycle and
//   checked by a separate monitor.
// ----------------------------------------------------------------------------
module tb_opl3_slot_sequencer;

   localparam int CLK_DIV   = 256;
   localparam int OPS       = 18;
   localparam int SP        = 4;
   localparam int NSLOT     = 36;
   localparam int FRAME_LEN = NSLOT * SP;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sample_clk_en;
   logic       op_sample_clk_en;
   logic       bank_num;
   logic [4:0] op_num;
   logic       frame_done;
   logic       regfile_wr_en;
   logic [8:0] regfile_wr_addr;
   logic [7:0] regfile_wr_data;

   opl3_slot_sequencer_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) hif ();

   opl3_slot_sequencer dut (
      .clk              (clk),
      .reset            (reset),
      .host             (hif),
      .sample_clk_en    (sample_clk_en),
      .op_sample_clk_en (op_sample_clk_en),
      .bank_num         (bank_num),
      .op_num           (op_num),
      .frame_done       (frame_done),
      .regfile_wr_en    (regfile_wr_en),
      .regfile_wr_addr  (regfile_wr_addr),
      .regfile_wr_data  (regfile_wr_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         ack_cyc;
      logic [8:0] addr;
      logic [7:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   cyc;
   int   vectors = 0;
   int   miscompares = 0;
   int   last_ack_exp = -100;
   logic prev_ack = 1'b0;

   // Clock edges since reset release.
   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   // ---------------- reference model ----------------
   function automatic int frame_pos(input int c);
      if (c < CLK_DIV) return -1;
      return c % CLK_DIV;
   endfunction

   function automatic int m_sample(input int c);
      return (c >= CLK_DIV && (c % CLK_DIV) == 0) ? 1 : 0;
   endfunction

   function automatic int m_latch(input int c);
      int p;
      p = frame_pos(c);
      return (p >= 1 && p <= FRAME_LEN && ((p - 1) % SP) == 0) ? 1 : 0;
   endfunction

   function automatic int m_frame(input int c);
      return (frame_pos(c) == FRAME_LEN) ? 1 : 0;
   endfunction

   function automatic int m_slot(input int c);
      int p;
      p = frame_pos(c);
      if (c <= CLK_DIV) return 0;
      if (p >= 1 && p <= FRAME_LEN) return (p - 1) / SP;
      return NSLOT - 1;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         chk("rst_sample", int'(sample_clk_en), 0);
         chk("rst_latch", int'(op_sample_clk_en), 0);
         chk("rst_bank", int'(bank_num), 0);
         chk("rst_op", int'(op_num), 0);
         chk("rst_frame", int'(frame_done), 0);
         chk("rst_ack", int'(hif.host_wr_ack), 0);
         chk("rst_wren", int'(regfile_wr_en), 0);
         chk("rst_waddr", int'(regfile_wr_addr), 0);
         chk("rst_wdata", int'(regfile_wr_data), 0);
         prev_ack = 1'b0;
      end else begin
         chk("sample_clk_en", int'(sample_clk_en), m_sample(cyc));
         chk("op_sample_clk_en", int'(op_sample_clk_en), m_latch(cyc));
         chk("frame_done", int'(frame_done), m_frame(cyc));
         chk("bank_num", int'(bank_num), m_slot(cyc) / OPS);
         chk("op_num", int'(op_num), m_slot(cyc) % OPS);
         chk("ack_eq_wren", int'(hif.host_wr_ack), int'(regfile_wr_en));
         chk("ack_on_latch", int'(hif.host_wr_ack & op_sample_clk_en), 0);
         chk("ack_b2b", int'(hif.host_wr_ack & prev_ack), 0);
         if (regfile_wr_en) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_write", 1, 0);
            end else begin
               e = sb_q.pop_front();
               chk("ack_cycle", cyc, e.ack_cyc);
               chk("wr_addr", int'(regfile_wr_addr), int'(e.addr));
               chk("wr_data", int'(regfile_wr_data), int'(e.data));
            end
         end else if (sb_q.size() > 0 && cyc > sb_q[0].ack_cyc) begin
            chk("ack_missing", 0, 1);
            void'(sb_q.pop_front());
         end
         prev_ack = hif.host_wr_ack;
      end
   end

   // ---------------- stimulus ----------------
   // Called at a falling edge: request becomes visible for the coming edge.
   task automatic issue(input logic [8:0] a, input logic [7:0] d);
      int   t;
      exp_t e;
      hif.host_wr_req  = 1'b1;
      hif.host_wr_addr = a;
      hif.host_wr_data = d;
      t = cyc;
      // Grant at edge ending t needs no ack in cycle t and cycle t+1 not a latch cycle.
      while (t == last_ack_exp || m_latch(t + 1) != 0) t++;
      e.ack_cyc = t + 1;
      e.addr    = a;
      e.data    = d;
      sb_q.push_back(e);
      last_ack_exp = t + 1;
   endtask

   task automatic wait_ack();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (hif.host_wr_ack) return;
      end
   endtask

   task automatic wait_cyc(input int c);
      @(negedge clk);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic random_traffic(input int until_cyc);
      int start;
      while (cyc < until_cyc) begin
         repeat ($urandom_range(0, 5)) @(negedge clk);
         if ($urandom_range(0, 3) == 0) begin
            // Request held high across successive grants for 20 cycles.
            start = cyc;
            do begin
               issue(9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)));
               wait_ack();
            end while (cyc - start < 20);
         end else begin
            issue(9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)));
            wait_ack();
         end
         hif.host_wr_req = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      hif.host_wr_req  = 1'b0;
      hif.host_wr_addr = 9'd0;
      hif.host_wr_data = 8'd0;
      repeat (10) @(negedge clk);
      #2 reset = 1'b0;

      // Request whose next cycle is a latch cycle (N+4 with N=256).
      wait_cyc(260);
      issue(9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)));
      wait_ack();
      hif.host_wr_req = 1'b0;

      // Request on a non-latch cycle (N+10).
      wait_cyc(266);
      issue(9'h1A0, 8'h5C);
      wait_ack();
      hif.host_wr_req = 1'b0;

      random_traffic(1000);

      // Reset in the middle of a frame with a request pending.
      wait_cyc(1084);
      #2;
      hif.host_wr_req  = 1'b1;
      hif.host_wr_addr = 9'h0F3;
      hif.host_wr_data = 8'hA5;
      reset = 1'b1;
      #1;
      chk("rst_now_sample", int'(sample_clk_en), 0);
      chk("rst_now_latch", int'(op_sample_clk_en), 0);
      chk("rst_now_bank", int'(bank_num), 0);
      chk("rst_now_op", int'(op_num), 0);
      chk("rst_now_frame", int'(frame_done), 0);
      chk("rst_now_ack", int'(hif.host_wr_ack), 0);
      chk("rst_now_waddr", int'(regfile_wr_addr), 0);
      chk("rst_now_wdata", int'(regfile_wr_data), 0);
      repeat (5) @(negedge clk);
      hif.host_wr_req = 1'b0;
      last_ack_exp = -100;
      #2 reset = 1'b0;

      random_traffic(700);
      repeat (4) @(negedge clk);
      chk("queue_drained", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
